// File: rtl/alu_pkg.sv
// Shared ALU encodings: AluOp classes, funct fields and ALU control codes.
// The ALU, the main controller and the EX-stage control sequencer all import this.
package alu_pkg;

    // AluOp classes driven by the main controller
    localparam logic [3:0] DC       = 4'b0000;
    localparam logic [3:0] ADDI_OP  = 4'b0001;
    localparam logic [3:0] SUBI_OP  = 4'b0010;
    localparam logic [3:0] ORI_OP   = 4'b0011;
    localparam logic [3:0] ANDI_OP  = 4'b0100;
    localparam logic [3:0] XORI_OP  = 4'b0101;
    localparam logic [3:0] NORI_OP  = 4'b0110;
    localparam logic [3:0] ADDIU_OP = 4'b0111;
    localparam logic [3:0] BR_OP    = 4'b1000;
    localparam logic [3:0] MULI_OP  = 4'b1001;
    localparam logic [3:0] SLTI_OP  = 4'b1010;
    localparam logic [3:0] SLTIU_OP = 4'b1011;
    localparam logic [3:0] MUL_OP   = 4'b1100;

    // R-type funct fields
    localparam logic [5:0] FC_SLL     = 6'b000000;
    localparam logic [5:0] FC_SRL     = 6'b000010;
    localparam logic [5:0] FC_SRA     = 6'b000011;
    localparam logic [5:0] FC_SLLV    = 6'b000100;
    localparam logic [5:0] FC_ROTRV   = 6'b000110;
    localparam logic [5:0] FC_SRAV    = 6'b000111;
    localparam logic [5:0] FC_MOVZ    = 6'b001010;
    localparam logic [5:0] FC_MOVN    = 6'b001011;
    localparam logic [5:0] FC_MULT    = 6'b011000;
    localparam logic [5:0] FC_MULTU   = 6'b011001;
    localparam logic [5:0] FC_ADD     = 6'b100000;
    localparam logic [5:0] FC_SEH_SEB = 6'b100000;
    localparam logic [5:0] FC_ADDU    = 6'b100001;
    localparam logic [5:0] FC_SUB     = 6'b100010;
    localparam logic [5:0] FC_AND     = 6'b100100;
    localparam logic [5:0] FC_OR      = 6'b100101;
    localparam logic [5:0] FC_XOR     = 6'b100110;
    localparam logic [5:0] FC_NOR     = 6'b100111;
    localparam logic [5:0] FC_SLT     = 6'b101010;
    localparam logic [5:0] FC_SLTU    = 6'b101011;
    // SPECIAL2 funct fields (AluOp MUL_OP)
    localparam logic [5:0] FC_MADD    = 6'b000000;
    localparam logic [5:0] FC_MUL     = 6'b000010;
    localparam logic [5:0] FC_MSUB    = 6'b000100;

    // ALU control codes
    localparam logic [4:0] ADD      = 5'b00000;
    localparam logic [4:0] ADDU     = 5'b00001;
    localparam logic [4:0] SUB      = 5'b00010;
    localparam logic [4:0] MULT     = 5'b00011;
    localparam logic [4:0] MULTU    = 5'b00100;
    localparam logic [4:0] AND      = 5'b00101;
    localparam logic [4:0] OR       = 5'b00110;
    localparam logic [4:0] NOR      = 5'b00111;
    localparam logic [4:0] XOR      = 5'b01000;
    localparam logic [4:0] SLL      = 5'b01001;
    localparam logic [4:0] SRL      = 5'b01010;
    localparam logic [4:0] SLLV     = 5'b01011;
    localparam logic [4:0] SLT      = 5'b01100;
    localparam logic [4:0] MOVN     = 5'b01101;
    localparam logic [4:0] MOVZ     = 5'b01110;
    localparam logic [4:0] ROTRV    = 5'b01111;
    localparam logic [4:0] SRA      = 5'b10000;
    localparam logic [4:0] SRAV     = 5'b10001;
    localparam logic [4:0] SLTU     = 5'b10010;
    localparam logic [4:0] MUL      = 5'b10011;
    localparam logic [4:0] MADD     = 5'b10100;
    localparam logic [4:0] MSUB     = 5'b10101;
    localparam logic [4:0] SEH_SEB  = 5'b00000;

    function automatic logic is_mul_class(input logic [4:0] code);
        return (code == MULT) || (code == MULTU) || (code == MUL) ||
               (code == MADD) || (code == MSUB);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational {AluOp, Funct} -> ALU control code decoder with illegal flag.
// Undefined combinations decode to ADD with illegal set.
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter int AOP_W = 4
) (
    input  logic [AOP_W-1:0] AluOp,
    input  logic [5:0]       Funct,
    output logic [4:0]       code,
    output logic             illegal
);

    always_comb begin
        code    = ADD;
        illegal = 1'b0;
        case (AluOp)
            AOP_W'(DC): begin
                // seh/seb share funct 100000 with add; AluOp tells them apart upstream
                case (Funct)
                    FC_ADD:   code = ADD;
                    FC_ADDU:  code = ADDU;
                    FC_SUB:   code = SUB;
                    FC_MULT:  code = MULT;
                    FC_MULTU: code = MULTU;
                    FC_AND:   code = AND;
                    FC_OR:    code = OR;
                    FC_NOR:   code = NOR;
                    FC_XOR:   code = XOR;
                    FC_SLL:   code = SLL;
                    FC_SRL:   code = SRL;
                    FC_SLLV:  code = SLLV;
                    FC_SLT:   code = SLT;
                    FC_MOVN:  code = MOVN;
                    FC_MOVZ:  code = MOVZ;
                    FC_ROTRV: code = ROTRV;
                    FC_SRA:   code = SRA;
                    FC_SRAV:  code = SRAV;
                    FC_SLTU:  code = SLTU;
                    default:  illegal = 1'b1;
                endcase
            end
            AOP_W'(ADDI_OP):  code = ADD;
            AOP_W'(SUBI_OP):  code = SUB;
            AOP_W'(ORI_OP):   code = OR;
            AOP_W'(ANDI_OP):  code = AND;
            AOP_W'(XORI_OP):  code = XOR;
            AOP_W'(NORI_OP):  code = NOR;
            AOP_W'(ADDIU_OP): code = ADDU;
            AOP_W'(BR_OP):    code = SUB;
            AOP_W'(MULI_OP):  code = MULT;
            AOP_W'(SLTI_OP):  code = SLT;
            AOP_W'(SLTIU_OP): code = SLTU;
            AOP_W'(MUL_OP): begin
                case (Funct)
                    FC_MUL:  code = MUL;
                    FC_MADD: code = MADD;
                    FC_MSUB: code = MSUB;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control sequencer: registered decode plus a latency counter
// that holds the stage busy for multiply-class ops and pulses HiLoWrite at the end.
module alu_ctrl_seq
    import alu_pkg::*;
#(
    parameter int CTRL_W  = 5,
    parameter int AOP_W   = 4,
    parameter int MUL_LAT = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Valid_In,
    input  logic [AOP_W-1:0]  AluOp,
    input  logic [5:0]        Funct,
    input  logic              Stall_In,
    output logic              Ready_Out,
    output logic              Valid_Out,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              MulBusy,
    output logic              HiLoWrite,
    output logic              Illegal
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       code_p0;
    logic [4:0]       dec_code;
    logic             dec_ill;
    logic             accept;

    alu_ctrl_decode #(.AOP_W(AOP_W)) u_decode (
        .AluOp   (AluOp),
        .Funct   (Funct),
        .code    (dec_code),
        .illegal (dec_ill)
    );

    assign Ready_Out  = (state == IDLE) && !Stall_In;
    assign accept     = Valid_In && Ready_Out;
    assign ALUControl = CTRL_W'(code_p0);

    // decode -> p0 register stage
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            cnt       <= '0;
            code_p0   <= ADD;
            Valid_Out <= 1'b0;
            MulBusy   <= 1'b0;
            HiLoWrite <= 1'b0;
            Illegal   <= 1'b0;
        end else if (!Stall_In) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        code_p0 <= dec_code;
                        Illegal <= dec_ill;
                        if (is_mul_class(dec_code) && MUL_LAT > 1) begin
                            state     <= MUL_BUSY;
                            cnt       <= CNT_W'(MUL_LAT - 1);
                            MulBusy   <= 1'b1;
                            Valid_Out <= 1'b0;
                            HiLoWrite <= 1'b0;
                        end else begin
                            MulBusy   <= 1'b0;
                            Valid_Out <= 1'b1;
                            HiLoWrite <= is_mul_class(dec_code) && (dec_code != MUL);
                        end
                    end else begin
                        MulBusy   <= 1'b0;
                        Valid_Out <= 1'b0;
                        HiLoWrite <= 1'b0;
                    end
                end
                MUL_BUSY: begin
                    cnt <= cnt - 1'b1;
                    // MulBusy stays high through the completion cycle; IDLE clears it
                    if (cnt == CNT_W'(1)) begin
                        state     <= IDLE;
                        Valid_Out <= 1'b1;
                        HiLoWrite <= (code_p0 != MUL);
                    end else begin
                        Valid_Out <= 1'b0;
                        HiLoWrite <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: decode table, multi-cycle corner
// sequences and a randomized run against a transaction-level reference model.
module tb_alu_ctrl_seq;

    localparam int LAT = 4;

    logic       Clk = 1'b0;
    logic       Rst, Valid_In, Stall_In;
    logic [3:0] AluOp;
    logic [5:0] Funct;
    logic       Ready_Out, Valid_Out, MulBusy, HiLoWrite, Illegal;
    logic [4:0] ALUControl;

    alu_ctrl_seq #(.CTRL_W(5), .AOP_W(4), .MUL_LAT(LAT)) dut (
        .Clk(Clk), .Rst(Rst), .Valid_In(Valid_In), .AluOp(AluOp), .Funct(Funct),
        .Stall_In(Stall_In), .Ready_Out(Ready_Out), .Valid_Out(Valid_Out),
        .ALUControl(ALUControl), .MulBusy(MulBusy), .HiLoWrite(HiLoWrite),
        .Illegal(Illegal)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference decode: returns {illegal, code}
    function automatic logic [5:0] ref_dec(input logic [3:0] a, input logic [5:0] f);
        case (a)
            4'd0: case (f)
                6'b100000: return 6'd0;   6'b100001: return 6'd1;
                6'b100010: return 6'd2;   6'b011000: return 6'd3;
                6'b011001: return 6'd4;   6'b100100: return 6'd5;
                6'b100101: return 6'd6;   6'b100111: return 6'd7;
                6'b100110: return 6'd8;   6'b000000: return 6'd9;
                6'b000010: return 6'd10;  6'b000100: return 6'd11;
                6'b101010: return 6'd12;  6'b001011: return 6'd13;
                6'b001010: return 6'd14;  6'b000110: return 6'd15;
                6'b000011: return 6'd16;  6'b000111: return 6'd17;
                6'b101011: return 6'd18;
                default:   return 6'b100000;
            endcase
            4'd1: return 6'd0;   4'd2: return 6'd2;   4'd3: return 6'd6;
            4'd4: return 6'd5;   4'd5: return 6'd8;   4'd6: return 6'd7;
            4'd7: return 6'd1;   4'd8: return 6'd2;   4'd9: return 6'd3;
            4'd10: return 6'd12; 4'd11: return 6'd18;
            4'd12: case (f)
                6'b000010: return 6'd19;
                6'b000000: return 6'd20;
                6'b000100: return 6'd21;
                default:   return 6'b100000;
            endcase
            default: return 6'b100000;
        endcase
    endfunction

    function automatic logic ref_is_mul(input logic [4:0] c);
        return c == 5'd3 || c == 5'd4 || c == 5'd19 || c == 5'd20 || c == 5'd21;
    endfunction

    // Reference model: remaining unstalled cycles of the multiply in flight
    int         m_left = 0;
    logic       m_valid = 0, m_hilo = 0, m_busy = 0, m_ill = 0;
    logic [4:0] m_code = 0;

    task automatic model_edge();
        logic [5:0] d;
        if (Rst) begin
            m_left = 0; m_valid = 0; m_hilo = 0; m_busy = 0; m_ill = 0; m_code = 0;
        end else if (Stall_In) begin
            // frozen
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1;
                m_hilo  = (m_code != 5'd19);
            end
        end else if (Valid_In) begin
            d = ref_dec(AluOp, Funct);
            m_code = d[4:0];
            m_ill  = d[5];
            if (ref_is_mul(m_code) && LAT > 1) begin
                m_left = LAT - 1; m_busy = 1; m_valid = 0; m_hilo = 0;
            end else begin
                m_busy = 0; m_valid = 1; m_hilo = ref_is_mul(m_code) && m_code != 5'd19;
            end
        end else begin
            m_busy = 0; m_valid = 0; m_hilo = 0;
        end
    endtask

    // Inputs are already set by the caller; advances one clock and compares.
    task automatic step();
        #1;
        if (!Rst) chk("Ready_Out", Ready_Out, (m_left == 0) && !Stall_In);
        model_edge();
        @(posedge Clk);
        #1;
        chk("Valid_Out", Valid_Out, m_valid);
        chk("HiLoWrite", HiLoWrite, m_hilo);
        chk("MulBusy", MulBusy, m_busy);
        chk("Illegal", Illegal, m_ill);
        chk("ALUControl", ALUControl, m_code);
    endtask

    typedef struct {
        logic [3:0] aop;
        logic [5:0] f;
        logic [4:0] code;
        logic       ill;
    } vec_t;
    vec_t tbl[$];

    task automatic add_vec(input logic [3:0] a, input logic [5:0] f,
                           input logic [4:0] c, input logic i);
        vec_t v;
        v.aop = a; v.f = f; v.code = c; v.ill = i;
        tbl.push_back(v);
    endtask

    logic [5:0] fl[23] = '{6'b100000, 6'b100001, 6'b100010, 6'b011000, 6'b011001,
                           6'b100100, 6'b100101, 6'b100111, 6'b100110, 6'b000000,
                           6'b000010, 6'b000100, 6'b101010, 6'b001011, 6'b001010,
                           6'b000110, 6'b000011, 6'b000111, 6'b101011, 6'b111111,
                           6'b000001, 6'b110000, 6'b011010};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_valid, hilo_cnt, valid_cnt;

        add_vec(4'd0, 6'b100100, 5'd5,  0);   // and
        add_vec(4'd10, 6'b000000, 5'd12, 0);  // slti
        add_vec(4'd11, 6'b000000, 5'd18, 0);  // sltiu
        add_vec(4'd0, 6'b100000, 5'd0,  0);   add_vec(4'd0, 6'b100001, 5'd1,  0);
        add_vec(4'd0, 6'b100010, 5'd2,  0);   add_vec(4'd0, 6'b100101, 5'd6,  0);
        add_vec(4'd0, 6'b100111, 5'd7,  0);   add_vec(4'd0, 6'b100110, 5'd8,  0);
        add_vec(4'd0, 6'b000000, 5'd9,  0);   add_vec(4'd0, 6'b000010, 5'd10, 0);
        add_vec(4'd0, 6'b000100, 5'd11, 0);   add_vec(4'd0, 6'b101010, 5'd12, 0);
        add_vec(4'd0, 6'b001011, 5'd13, 0);   add_vec(4'd0, 6'b001010, 5'd14, 0);
        add_vec(4'd0, 6'b000110, 5'd15, 0);   add_vec(4'd0, 6'b000011, 5'd16, 0);
        add_vec(4'd0, 6'b000111, 5'd17, 0);   add_vec(4'd0, 6'b101011, 5'd18, 0);
        add_vec(4'd1, 6'b010101, 5'd0,  0);   add_vec(4'd2, 6'b000000, 5'd2,  0);
        add_vec(4'd3, 6'b000000, 5'd6,  0);   add_vec(4'd4, 6'b000000, 5'd5,  0);
        add_vec(4'd5, 6'b000000, 5'd8,  0);   add_vec(4'd6, 6'b000000, 5'd7,  0);
        add_vec(4'd7, 6'b000000, 5'd1,  0);   add_vec(4'd8, 6'b000000, 5'd2,  0);
        add_vec(4'd12, 6'b111111, 5'd0, 1);   add_vec(4'd15, 6'b000000, 5'd0, 1);
        add_vec(4'd0, 6'b111111, 5'd0,  1);   add_vec(4'd13, 6'b100000, 5'd0, 1);
        add_vec(4'd6, 6'b000000, 5'd7,  0);   // legal after illegal clears the flag

        // Reset with a valid op presented: nothing accepted
        Rst = 1; Valid_In = 1; AluOp = 4'd0; Funct = 6'b100010; Stall_In = 0;
        step();
        step();
        chk("rst_valid", Valid_Out, 0);
        chk("rst_code", ALUControl, 0);
        chk("rst_busy", MulBusy, 0);
        chk("rst_hilo", HiLoWrite, 0);
        chk("rst_ill", Illegal, 0);
        chk("rst_ready", Ready_Out, 1);
        Rst = 0; Valid_In = 0;
        step();

        // Back-to-back decode table, one op per cycle
        foreach (tbl[i]) begin
            Valid_In = 1; AluOp = tbl[i].aop; Funct = tbl[i].f;
            step();
            chk($sformatf("tbl%0d_code", i), ALUControl, tbl[i].code);
            chk($sformatf("tbl%0d_ill", i), Illegal, tbl[i].ill);
            chk($sformatf("tbl%0d_valid", i), Valid_Out, 1);
            chk($sformatf("tbl%0d_busy", i), MulBusy, 0);
        end
        Valid_In = 0;
        step();
        chk("idle_valid_drop", Valid_Out, 0);
        chk("idle_code_hold", ALUControl, 5'd7);

        // MULT: busy N+1..N+4, completion at N+4
        Valid_In = 1; AluOp = 4'd0; Funct = 6'b011000;
        step();
        Valid_In = 0;
        for (int k = 1; k <= LAT; k++) begin
            chk($sformatf("mult_busy_%0d", k), MulBusy, 1);
            chk($sformatf("mult_ready_%0d", k), Ready_Out, k == LAT);
            chk($sformatf("mult_valid_%0d", k), Valid_Out, k == LAT);
            chk($sformatf("mult_hilo_%0d", k), HiLoWrite, k == LAT);
            if (k < LAT) step();
        end
        chk("mult_code", ALUControl, 5'd3);
        step();
        chk("mult_after_busy", MulBusy, 0);
        chk("mult_after_hilo", HiLoWrite, 0);

        // MUL: same latency, no HI/LO write
        Valid_In = 1; AluOp = 4'd12; Funct = 6'b000010;
        step();
        Valid_In = 0;
        for (int k = 1; k <= LAT; k++) begin
            chk($sformatf("mul_valid_%0d", k), Valid_Out, k == LAT);
            chk($sformatf("mul_hilo_%0d", k), HiLoWrite, 0);
            if (k < LAT) step();
        end
        chk("mul_code", ALUControl, 5'd19);
        step();

        // MADD with a 3-cycle stall on its final busy cycle
        Valid_In = 1; AluOp = 4'd12; Funct = 6'b000000;
        step();
        Valid_In = 0;
        first_valid = -1; hilo_cnt = 0;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            if (Valid_Out && first_valid < 0) first_valid = cyc;
            if (HiLoWrite && !Stall_In) hilo_cnt++;
            if (cyc == 3) Stall_In = 1;
            if (cyc == 6) Stall_In = 0;
            step();
        end
        chk("madd_stall_latency", first_valid, LAT + 3);
        chk("madd_single_hilo", hilo_cnt, 1);
        chk("madd_code", ALUControl, 5'd20);

        // MSUB aborted by reset
        Valid_In = 1; AluOp = 4'd12; Funct = 6'b000100;
        step();
        Valid_In = 0;
        step();
        Rst = 1;
        step();
        chk("abort_busy", MulBusy, 0);
        chk("abort_valid", Valid_Out, 0);
        chk("abort_hilo", HiLoWrite, 0);
        chk("abort_ready", Ready_Out, 1);
        Rst = 0;
        hilo_cnt = 0; valid_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            hilo_cnt += int'(HiLoWrite);
            valid_cnt += int'(Valid_Out);
        end
        chk("abort_no_hilo", hilo_cnt, 0);
        chk("abort_no_valid", valid_cnt, 0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            Rst      = ($urandom_range(0, 99) == 0);
            Valid_In = ($urandom_range(0, 9) < 7);
            Stall_In = ($urandom_range(0, 9) < 2);
            AluOp    = 4'($urandom_range(0, 15));
            Funct    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 22)];
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, handshaked successor to the combinational ALU control decoder in the EX stage. It maps {AluOp, Funct} to the 5-bit ALU control code through one pipeline register and tracks multi-cycle multiply operations with a latency counter. While a multiply is in flight it holds the stage busy, and on completion it pulses the HI/LO write enable. It sits between ID/EX and the ALU/multiplier, and drives the hazard unit's stall input.

## Interface
Parameters:
- CTRL_W, 5: ALU control code width.
- AOP_W, 4: AluOp width.
- MUL_LAT, 4: cycles from accept to result for multiply-class ops. Legal range is 1..15.

Ports:
- Clk, in, 1: clock, rising edge.
- Rst, in, 1: reset, synchronous, active-high.
- Valid_In, in, 1: AluOp/Funct valid this cycle.
- AluOp, in, AOP_W: opcode class from the main controller.
- Funct, in, 6: instruction funct field.
- Stall_In, in, 1: downstream stall. Freezes the block.
- Ready_Out, out, 1: the block can accept this cycle.
- Valid_Out, out, 1: ALUControl and flags are valid.
- ALUControl, out, CTRL_W: registered ALU control code.
- MulBusy, out, 1: a multiply-class op is in flight (to the hazard unit).
- HiLoWrite, out, 1: one-cycle pulse at completion of MULT/MULTU/MADD/MSUB.
- Illegal, out, 1: the accepted AluOp/Funct combination is undefined.

## Operation
- Decode table:
  - AluOp 0000 decodes Funct as follows: add→00000, addu→00001, sub→00010, mult→00011, multu→00100, and→00101, or→00110, nor→00111, xor→01000, sll→01001, srl→01010, sllv→01011, slt→01100, movn→01101, movz→01110, rotrv→01111, sra→10000, srav→10001, sltu→10010, seh/seb(100000) shares add's code and is resolved by AluOp, not here.
  - Immediate classes: 0001→ADD, 0010→SUB, 0011→OR, 0100→AND, 0101→XOR, 0110→NOR, 0111→ADDU, 1000→SUB, 1001→MULT, 1010→SLT, 1011→SLTU.
  - AluOp 1100 decodes Funct: 000010→MUL 10011, 000000→MADD 10100, 000100→MSUB 10101.
- Any undefined Funct or AluOp gives ALUControl=ADD and Illegal=1. No latch or hold behaviour is permitted.
- Multiply class is MULT, MULTU, MUL, MADD and MSUB. All other codes are single-cycle.
- accept = Valid_In & Ready_Out. Ready_Out = (state==IDLE) & ~Stall_In.
- FSM:
  - IDLE: on accept, register the code and flags.
    - Single-cycle op: Valid_Out=1 next cycle; stay in IDLE.
    - Multiply class with MUL_LAT>1: go to MUL, load cnt=MUL_LAT-1, MulBusy=1, Valid_Out=0.
    - Multiply class with MUL_LAT=1: behaves as single-cycle.
  - MUL: each cycle where ~Stall_In, cnt decrements. When cnt reaches 0, Valid_Out=1 for one cycle; HiLoWrite=1 in the same cycle unless the op is MUL; return to IDLE.
  - No accept in MUL.
- Stall_In=1 freezes the state, cnt and all outputs (Valid_Out and HiLoWrite are held, not re-pulsed as new events).
- Without accept in IDLE, Valid_Out drops to 0. ALUControl holds its last value.

## Timing
- Reset values: ALUControl=00000, Valid_Out=0, MulBusy=0, HiLoWrite=0, Illegal=0, Ready_Out=~Stall_In, state=IDLE, cnt=0.
- Latency, single-cycle op: accept at cycle N gives Valid_Out at N+1. Back-to-back accepts sustain 1 op/cycle.
- Latency, multiply class: accept at N gives MulBusy during N+1..N+MUL_LAT and Valid_Out/HiLoWrite at N+MUL_LAT. Ready_Out returns at N+MUL_LAT, so the next accept is possible at that cycle.
- Rst asserted mid-multiply aborts it: next cycle IDLE, no HiLoWrite, Valid_Out=0.
- Rst has priority over accept and Stall_In.
- Stall_In during the final MUL cycle delays completion; HiLoWrite fires exactly once per multiply.

## Structure
- Shared package alu_pkg holds:
  - AluOp class localparams (DC..MUL_OP).
  - Funct localparams (FC_*).
  - ALU control codes (ADD..SEH_SEB).
  - Function is_mul_class(code).
  - ALU and the main controller import the same package.
- Sub-module alu_ctrl_decode: purely combinational {AluOp, Funct}→{code, illegal}. alu_ctrl_seq holds the registers, FSM and counter.
- cnt width: $clog2(MUL_LAT+1).

## Test plan
- Reset: Rst=1 for 2 cycles with Valid_In=1, AluOp=0000, Funct=100010 → all outputs at reset values; no Valid_Out.
- Streaming: accept and(100100), slti(1010), sltiu(1011) on consecutive cycles → ALUControl 00101, 01100, 10010 on consecutive cycles, Valid_Out=1 each, MulBusy=0.
- Multiply, MUL_LAT=4: accept AluOp 0000/Funct 011000 at N → MulBusy N+1..N+4, Ready_Out=0 N+1..N+3, Valid_Out and HiLoWrite=1 only at N+4, ALUControl=00011.
- MUL op: AluOp 1100/Funct 000010 → ALUControl 10011 after MUL_LAT cycles, HiLoWrite stays 0.
- Stall and abort: Stall_In=1 for 3 cycles mid-MADD → completion delayed 3 cycles, single HiLoWrite. Rst mid-MSUB → IDLE next cycle, HiLoWrite never asserted.
- Illegal: AluOp 1100/Funct 111111, and AluOp 1111 → ALUControl 00000, Illegal=1, Valid_Out=1 next cycle.
